// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_seq
//  Description : Holds a PLL in reset, waits for a filtered lock, then
//                releases N_CH downstream resets in fixed order with a
//                programmable stagger. Any lock loss re-sequences the PLL.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
  parameter int N_CH           = 3,
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_FILTER    = 8,
  parameter int LOCK_TIMEOUT   = 100,
  parameter int STAGGER        = 2,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic [N_CH-1:0]  rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  // One shared phase counter serves every timed state; size it for the longest.
  localparam int MAX_PF = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
  localparam int MAX_TS = (LOCK_TIMEOUT > STAGGER) ? LOCK_TIMEOUT : STAGGER;
  localparam int MAXC   = (MAX_PF > MAX_TS) ? MAX_PF : MAX_TS;
  localparam int CW     = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sync1_q, sync2_q;
  logic              pll_rst_q, pll_rst_d;
  logic [N_CH-1:0]   rst_out_q, rst_out_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  loss_q, loss_d;
  logic [CNT_W-1:0]  retry_q, retry_d;
  logic              locked_s;
  logic              start_rel;
  logic              lose;
  logic [N_CH-1:0]   rst_shift;

  // Channels release LSB first: shifting a zero in from the bottom makes the
  // order structurally fixed and impossible to reverse.
  assign rst_shift = rst_out_q << 1;
  assign locked_s  = sync2_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizer: the only consumer of the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // State, phase counter, registered outputs and event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pll_rst_d = pll_rst_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    loss_d    = loss_q;
    retry_d   = retry_q;
    start_rel = 1'b0;
    lose      = 1'b0;

    case (state_q)
      S_PLLRST: begin
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
          state_d   = S_WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          // The cycle that reveals lock is the first filtered lock cycle.
          if (LOCK_FILTER <= 1) begin
            start_rel = 1'b1;
          end else begin
            state_d = S_FILTER;
            cnt_d   = CW'(1);
          end
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d   = S_PLLRST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
          retry_d   = sat_inc(retry_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FILTER: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_FILTER - 1)) begin
          start_rel = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          lose = 1'b1;
        end else if (cnt_q == CW'(STAGGER - 1)) begin
          cnt_d     = '0;
          rst_out_d = rst_shift;
          if (rst_shift == '0) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) lose = 1'b1;
      end
      default: begin
        state_d   = S_PLLRST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    endcase

    // Channel 0 drops together with entry into RELEASE; a single channel
    // means the whole release completes in that same cycle.
    if (start_rel) begin
      cnt_d     = '0;
      rst_out_d = rst_shift;
      if (rst_shift == '0) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end else begin
        state_d = S_RELEASE;
      end
    end

    // Lock loss overrides any release scheduled for the same cycle.
    if (lose) begin
      state_d   = S_PLLRST;
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      rst_out_d = '1;
      ready_d   = 1'b0;
      loss_d    = sat_inc(loss_q);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign rst_out       = rst_out_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;

endmodule
`default_nettype wire

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter N_CH, default 3, number of downstream reset channels (1..16).
REQ-002 Parameter PLL_RST_CYCLES, default 4, cycles pll_rst is held high per PLL (re)start.
REQ-003 Parameter LOCK_FILTER, default 8, consecutive synchronized-lock cycles required before release.
REQ-004 Parameter LOCK_TIMEOUT, default 100, cycles allowed in WAIT_LOCK before a PLL retry.
REQ-005 Parameter STAGGER, default 2, cycles between successive channel releases (>=1).
REQ-006 Parameter CNT_W, default 8, width of the event counters.
REQ-007 clk  input  1  free-running reference clock (PLL input clock); all logic on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset; assertion is immediate, deassertion is used on clk.
REQ-009 pll_locked  input  1  PLL LOCK output, asynchronous to clk.
REQ-010 pll_rst  output  1  active-high drive to PLL RST.
REQ-011 rst_out  output  N_CH  active-high per-domain resets; bit i released in order i=0..N_CH-1.
REQ-012 ready  output  1  high when all channels are released and lock is stable.
REQ-013 lock_loss_cnt  output  CNT_W  count of lock losses after ready or during release.
REQ-014 retry_cnt  output  CNT_W  count of WAIT_LOCK timeouts.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); no other logic samples pll_locked.
REQ-016 FSM states SHALL be PLLRST, WAIT_LOCK, FILTER, RELEASE, RUN; all outputs registered.
REQ-017 PLLRST: pll_rst=1, all rst_out=1, ready=0; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; timeout counter starts at 0 on entry; locked_s=1 -> FILTER.
REQ-019 WAIT_LOCK with no lock for LOCK_TIMEOUT cycles -> PLLRST and retry_cnt+1.
REQ-020 FILTER: counts consecutive locked_s=1 cycles; reaching LOCK_FILTER -> RELEASE; any locked_s=0 -> WAIT_LOCK with filter and timeout counters cleared.
REQ-021 RELEASE: rst_out[0] SHALL deassert in the first RELEASE cycle; rst_out[i] deasserts exactly STAGGER cycles after rst_out[i-1].
REQ-022 ready and the transition to RUN SHALL occur in the same cycle rst_out[N_CH-1] deasserts; N_CH=1 gives ready in the first RELEASE cycle.
REQ-023 RELEASE or RUN with locked_s=0: next cycle all rst_out=1, ready=0, pll_rst=1, lock_loss_cnt+1, state PLLRST (PLLRST count restarts).
REQ-024 Lock loss and a scheduled channel release in the same cycle: lock loss wins; no channel is released.
REQ-025 Both counters SHALL saturate at 2^CNT_W-1 and never wrap; they clear only on rst_n.
REQ-026 A released channel SHALL never re-release without passing through PLLRST; release order is fixed and never reversed.

Reset
REQ-027 While rst_n=0: state PLLRST, pll_rst=1, rst_out all ones, ready=0, both counters 0, synchronizer flops 0, internal counters 0.
REQ-028 rst_n asserted mid-RELEASE or RUN SHALL immediately force all rst_out=1 and ready=0; counters clear (no lock-loss count).
REQ-029 After rst_n deasserts, PLLRST lasts exactly PLL_RST_CYCLES cycles regardless of pll_locked.

Verification
REQ-030 Defaults; pll_locked held 1 from reset -> pll_rst high 4 cycles; rst_out[0] falls LOCK_FILTER=8 cycles after locked_s first high, [1] +2, [2] +4, ready with [2]; counters 0.
REQ-031 pll_locked never asserts, LOCK_TIMEOUT=100 -> pll_rst re-pulses for 4 cycles every 104 cycles; retry_cnt = 3 after the third timeout; rst_out stays 3'b111.
REQ-032 pll_locked glitches high 5 cycles then low during FILTER -> back to WAIT_LOCK, no release; then stable high -> release sequence of REQ-030.
REQ-033 In RUN, pll_locked drops for 1 synchronized cycle -> all rst_out=1 and ready=0 next cycle, lock_loss_cnt=1, full re-sequence after relock.
REQ-034 CNT_W=2, 5 lock losses -> lock_loss_cnt saturates at 3; rst_n low mid-RELEASE -> rst_out=3'b111, counts 0 at once.
REQ-035 N_CH=1, STAGGER=1 -> rst_out[0] and ready change together in the first RELEASE cycle.
